// File: rtl/car_controller.sv
// Four-floor elevator car controller: latches floor calls, sequences
// door and move intervals against an external kickable timer.
module car_controller #(
  parameter logic [1:0] RESET_FLOOR = 2'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       T,
  output logic       KT,
  output logic [1:0] floor,
  output logic       motor_up,
  output logic       motor_down,
  output logic       door_open,
  output logic [3:0] pending
);

  typedef enum logic [2:0] {
    IDLE,
    DOOR_KICK,
    DOOR_WAIT,
    MOVE_KICK,
    MOVE_WAIT
  } state_t;

  state_t     state, state_nx;
  logic       dir, dir_nx;
  logic [1:0] floor_nx;
  logic [3:0] pend_nx;
  logic       above, below, fwd, rev;
  logic       kt_nx, up_nx, dn_nx, door_nx;

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (pending[i] && i > int'(floor)) above = 1'b1;
      if (pending[i] && i < int'(floor)) below = 1'b1;
    end
    fwd = dir ? below : above;
    rev = dir ? above : below;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dir        <= 1'b0;
      floor      <= RESET_FLOOR;
      pending    <= 4'd0;
      KT         <= 1'b0;
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      door_open  <= 1'b0;
    end else begin
      state      <= state_nx;
      dir        <= dir_nx;
      floor      <= floor_nx;
      pending    <= pend_nx;
      KT         <= kt_nx;
      motor_up   <= up_nx;
      motor_down <= dn_nx;
      door_open  <= door_nx;
    end
  end

  // T is only meaningful in the WAIT states; KICK states may see stale T.
  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    floor_nx = floor;
    unique case (state)
      IDLE: begin
        if (pending[floor]) begin
          state_nx = DOOR_KICK;
        end else if (fwd) begin
          state_nx = MOVE_KICK;
        end else if (rev) begin
          state_nx = MOVE_KICK;
          dir_nx   = ~dir;
        end
      end
      DOOR_KICK: state_nx = DOOR_WAIT;
      DOOR_WAIT: if (T) state_nx = IDLE;
      MOVE_KICK: state_nx = MOVE_WAIT;
      MOVE_WAIT: begin
        if (T) begin
          state_nx = IDLE;
          floor_nx = dir ? floor - 2'd1 : floor + 2'd1;
        end
      end
      default: state_nx = IDLE;
    endcase

    pend_nx = pending | req;
    if (state == DOOR_KICK || state == DOOR_WAIT || state_nx == DOOR_KICK)
      pend_nx[floor] = 1'b0;
  end

  // Outputs are decoded from the next state so they land in flops.
  always_comb begin
    kt_nx   = 1'b0;
    up_nx   = 1'b0;
    dn_nx   = 1'b0;
    door_nx = 1'b0;
    unique case (1'b1)
      state_nx == DOOR_KICK: begin
        kt_nx   = 1'b1;
        door_nx = 1'b1;
      end
      state_nx == DOOR_WAIT: door_nx = 1'b1;
      state_nx == MOVE_KICK: begin
        kt_nx = 1'b1;
        up_nx = ~dir_nx;
        dn_nx = dir_nx;
      end
      state_nx == MOVE_WAIT: begin
        up_nx = ~dir_nx;
        dn_nx = dir_nx;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/car_controller.md
CAR_CONTROLLER -- requirements
Module: car_controller

Interface
REQ-001 Parameter RESET_FLOOR, default 2'd0, floor index loaded into floor on reset.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  floor call buttons, level, bit i = floor i, asynchronous to state.
REQ-005 T  input  1  timer-expired flag from timer; sticky high after expiry until the next KT is accepted.
REQ-006 KT  output  1  kick-timer pulse to timer; starts one timed interval.
REQ-007 floor  output  2  current car floor, 0..3.
REQ-008 motor_up  output  1  car moving up.
REQ-009 motor_down  output  1  car moving down.
REQ-010 door_open  output  1  door open.
REQ-011 pending  output  4  latched outstanding requests, bit i = floor i.

Function
REQ-012 States SHALL be IDLE, DOOR_KICK, DOOR_WAIT, MOVE_KICK, MOVE_WAIT; all outputs registered.
REQ-013 A direction register dir (0 = up, 1 = down) SHALL be kept internally; it resets to up.
REQ-014 Request latch: each cycle pending <= pending | req, except the bit for floor while in DOOR_KICK/DOOR_WAIT is held 0.
REQ-015 IDLE decision priority, one cycle per evaluation: pending[floor] -> DOOR_KICK; else requests in dir's direction -> MOVE_KICK in dir; else requests in opposite direction -> flip dir, MOVE_KICK; else stay IDLE.
REQ-016 "Requests above" means any pending bit with index > floor; "below" means index < floor.
REQ-017 Entering DOOR_KICK SHALL clear pending[floor] in the same edge.
REQ-018 KT SHALL be 1 exactly in DOOR_KICK and MOVE_KICK; each KICK state lasts exactly one cycle and then goes to its WAIT state.
REQ-019 T SHALL be ignored in KICK states (stale high from the previous interval); T is sampled only in WAIT states.
REQ-020 DOOR_WAIT: door_open = 1; on T = 1 -> IDLE next cycle.
REQ-021 door_open SHALL be 1 in DOOR_KICK and DOOR_WAIT, else 0.
REQ-022 MOVE_KICK/MOVE_WAIT: motor_up = ~dir, motor_down = dir; both 0 in all other states; never both 1.
REQ-023 MOVE_WAIT on T = 1: floor <= floor + 1 (up) or floor - 1 (down) and next state IDLE.
REQ-024 floor SHALL never wrap: MOVE_KICK is entered only when a request exists in the chosen direction, so up at floor 3 and down at floor 0 are unreachable.
REQ-025 A request arriving for the floor the car is currently moving away from SHALL be latched and served later by normal IDLE decision.
REQ-026 KT SHALL never be asserted on two consecutive cycles.
REQ-027 Latency: request at current floor in IDLE, sampled at edge n -> pending bit set at edge n, DOOR_KICK at edge n+1, door_open = 1 from cycle n+1.

Reset
REQ-028 On reset = 1 at a clock edge: state IDLE, floor = RESET_FLOOR, pending = 0, dir = up, KT = 0, motor_up = 0, motor_down = 0, door_open = 0.
REQ-029 Reset SHALL take priority over all transitions, including mid-move and mid-door-interval; the in-progress interval is abandoned and floor is not incremented.
REQ-030 req asserted during reset SHALL NOT be latched.

Verification
REQ-031 Reset, req = 4'b0100 one cycle, timer model count = 8 -> MOVE up twice (two KT pulses, floor 0->1->2), then DOOR_KICK, pending = 0, door_open until T, then IDLE with all outputs 0.
REQ-032 At floor 1 moving up, req = 4'b1001 -> serve floor 3 first (continue up), dir flips, then travel down to floor 0; pending bit clears on each door opening.
REQ-033 In DOOR_WAIT at floor 2, req = 4'b0100 held -> pending[2] stays 0, door closes on T, no re-open.
REQ-034 Stale T = 1 on DOOR_KICK cycle -> controller stays in DOOR_WAIT until timer raises T again; KT pulse width exactly 1.
REQ-035 Reset asserted in MOVE_WAIT with floor = 1 -> next cycle floor = RESET_FLOOR, motors 0, pending 0.
REQ-036 Idle with req = 0 for 100 cycles -> KT never asserted, outputs constant.
